// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor controller: state encoding,
// width limits and counter sizing.
package sub_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int unsigned WIDTH_MIN = 1;
  localparam int unsigned WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_t;

  // Bit index counter needs at least one bit even for a 1-bit word.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 32'd1 : 32'($clog2(w));
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Operand/result handshake bundle for serial_sub_ctrl.
interface serial_sub_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout
  );

endinterface

// File: rtl/full_sub_cell.sv
// 1-bit full subtractor (a - b - ci) built from a 3-to-8 minterm decoder.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic d,
  output logic co
);

  logic [7:0] m;

  always_comb begin
    m = 8'b0;
    m[{a, b, ci}] = 1'b1;
  end

  assign d  = m[1] | m[2] | m[4] | m[7];
  assign co = m[1] | m[2] | m[3] | m[7];

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: sequences one full_sub_cell LSB first and
// holds the borrow between bits; operands in and result out via valid/ready.
module serial_sub_ctrl
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_sub_ctrl_if.slave  bus
);

  localparam int unsigned CW = cnt_width(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_sub_ctrl: WIDTH out of range");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [WIDTH-1:0] diff_shift;
  logic [WIDTH-1:0] diff_q;
  logic             brw;
  logic             bout_q;
  logic [CW-1:0]    cnt;
  logic             load;
  logic             step;
  logic             last;
  logic             cell_d;
  logic             cell_co;

  full_sub_cell u_cell (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (brw),
    .d  (cell_d),
    .co (cell_co)
  );

  // Difference bit enters at the MSB so the word is aligned after WIDTH steps.
  assign diff_shift = (diff_sr >> 1) | (WIDTH'(cell_d) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath; result registers update only on the final RUN bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      brw     <= 1'b0;
      cnt     <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      if (load) begin
        a_sr <= bus.a;
        b_sr <= bus.b;
        brw  <= bus.bin;
        cnt  <= '0;
      end else if (step) begin
        a_sr    <= a_sr >> 1;
        b_sr    <= b_sr >> 1;
        diff_sr <= diff_shift;
        brw     <= cell_co;
        cnt     <= cnt + CW'(1);
      end
      if (last) begin
        diff_q <= diff_shift;
        bout_q <= cell_co;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial multi-bit subtractor controller: accepts two WIDTH-bit operands and a borrow-in through a valid/ready handshake. It computes A − B − BIN one bit per cycle, LSB first, by sequencing a single 1-bit full-subtractor cell and holding the borrow in a register between bits. The difference and borrow-out are presented through a valid/ready output handshake. It sits between an operand source and a result consumer, letting the team reuse the small decoder-based full-subtractor cell for arbitrary word widths.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; asserted asynchronously, released synchronously to clk by the system.
- in_valid  input  1  operand source has A/B/BIN valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in for bit 0.
- out_valid  output  1  diff/bout valid (high only in DONE).
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (A − B − BIN) mod 2^WIDTH.
- bout  output  1  final borrow; 1 iff A < B + BIN (unsigned).

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - On in_valid && in_ready: load a_sr←a, b_sr←b, brw←bin, cnt←0; go to RUN.
  - a/b/bin are sampled only at the accept edge.
- RUN: the cell is fed A=a_sr[0], B=b_sr[0], Ci=brw. Each cycle:
  - a_sr and b_sr shift right by 1.
  - diff_sr shifts right, with cell D entering at bit WIDTH−1.
  - brw←cell Co.
  - cnt←cnt+1.
  - When cnt==WIDTH−1, that bit is processed and the state goes to DONE.
- DONE: out_valid=1; diff=diff_sr and bout=brw, both held stable. On out_ready, go to IDLE.
- Cell truth (A,B,Ci→D,Co): 000→00, 001→11, 010→11, 011→01, 100→10, 101→00, 110→00, 111→11.
- in_valid outside IDLE is ignored; no queuing.
- out_ready outside DONE is ignored.
- cnt width = max(1, $clog2(WIDTH)). For WIDTH=1, RUN lasts exactly one cycle.
- Illegal state encodings recover to IDLE.

## Timing
- Reset values:
  - state=IDLE, so in_ready=1 during and after reset.
  - out_valid=0, diff=0, bout=0.
  - cnt=0; brw, a_sr, b_sr, diff_sr all 0.
- Latency: out_valid rises WIDTH cycles after the accepting edge. Minimum throughput is one operation per WIDTH+2 cycles (accept, WIDTH RUN cycles, DONE handshake, IDLE).
- in_ready and out_valid are decoded directly from the state register (registered; no combinational path from inputs).
- Back-pressure: with out_ready low, DONE persists indefinitely and outputs do not change.
- DONE→IDLE on the out_ready edge. A new accept can happen on the following edge; there is no same-cycle IDLE bypass.
- Reset mid-RUN or mid-DONE: the in-flight operation is discarded, all outputs take their reset values immediately (asynchronously), and no partial result is ever presented.
- diff/bout may change only on the RUN→DONE transition edge.

## Structure
- Shared package sub_pkg:
  - State encoding localparams: ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - WIDTH legal limits.
- Sub-module full_sub_cell (combinational):
  - Inputs A, B, Ci; outputs D, Co.
  - Implemented with the team's 3-8 decoder: D = minterms 1,2,4,7; Co = minterms 1,2,3,7.
  - Instantiated once.
- Top holds the FSM, counter, shift registers and borrow register.

## Test plan
- WIDTH=8: a=200, b=55, bin=0 → diff=145, bout=0, out_valid exactly 8 cycles after accept.
- WIDTH=8: a=5, b=9, bin=0 → diff=252, bout=1. Then a=0, b=0, bin=1 → diff=255, bout=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE → out_valid, diff and bout remain stable; in_ready=0 throughout. Release → IDLE next cycle.
- Toggle in_valid with new a/b during RUN → ignored; the result matches the originally accepted operands.
- Assert rst_n low at RUN cycle 3 → out_valid=0, diff=0, in_ready=1 at once. A fresh operation afterwards (a=100, b=1) → diff=99.
- WIDTH=1: all 8 (a,b,bin) combinations → (diff,bout) matches the cell truth table, with 1-cycle RUN each. Then a random back-to-back sweep at WIDTH=8 against a reference model.
